// File: rtl/qdec_cabac_package.sv
// Shared definitions for the CTU syntax line buffer: error-bit positions and
// the packed layout of the sticky error flags.
package qdec_cabac_package;

  localparam int ERR_WR_FULL   = 0;  // write or commit while no free bank
  localparam int ERR_RD_EMPTY  = 1;  // read while no committed bank
  localparam int ERR_REL_EMPTY = 2;  // release while no committed bank

  // Bit 0 is the last member, so the struct lines up with the index constants.
  typedef struct packed {
    logic rel_empty;
    logic rd_empty;
    logic wr_full;
  } t_lb_err_s;

endpackage

// File: rtl/qdec_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered output.
// The array has no reset. Only the output register resets, so a reset always
// leaves a known read value.
module qdec_sdp_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port: the array is never reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port: the output register keeps its last value when re is low.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/qdec_ctu_syntax_buf.sv
// N-bank CTU syntax line buffer. The writer fills the current write bank and
// commits it. The reader drains committed banks in commit order and releases
// each one when done. Bank pointers wrap modulo NUM_BANKS (any value 2..8,
// not only powers of two). A bank is either committed (reader side) or
// uncommitted (writer side), never both, so reads and writes cannot collide.
//
// Handshake: an operation is accepted only when its side is ready. Writes and
// commits need wr_rdy; reads and releases need rd_bank_vld. Both readiness
// signals come from the count before the clock edge. Requests that are not
// accepted are dropped and set the matching sticky error bit.
module qdec_ctu_syntax_buf
  import qdec_cabac_package::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 12,
  parameter int NUM_BANKS = 2,
  parameter int BANK_W    = $clog2(NUM_BANKS),
  parameter int CNT_W     = $clog2(NUM_BANKS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_en,
  input  logic              wr_commit,
  output logic              wr_rdy,
  output logic [BANK_W-1:0] wr_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_data_vld,
  input  logic              rd_release,
  output logic              rd_bank_vld,
  output logic [BANK_W-1:0] rd_bank,
  output logic [CNT_W-1:0]  used_cnt,
  output logic [2:0]        err_flags,
  input  logic              err_clr
);

  localparam int                DEPTH     = NUM_BANKS * (2 ** ADDR_W);
  localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(NUM_BANKS);

  logic [BANK_W-1:0] wr_bank_q;
  logic [BANK_W-1:0] rd_bank_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              rd_vld_q;
  t_lb_err_s         err_q;

  logic              do_write;
  logic              do_commit;
  logic              do_read;
  logic              do_release;
  logic [2:0]        err_set;

  // The pointer wraps with an explicit compare, so any bank count works.
  function automatic logic [BANK_W-1:0] next_bank(input logic [BANK_W-1:0] b);
    return (b == LAST_BANK) ? '0 : b + BANK_W'(1);
  endfunction

  assign wr_rdy      = (cnt_q != FULL_CNT);
  assign rd_bank_vld = (cnt_q != '0);
  assign wr_bank     = wr_bank_q;
  assign rd_bank     = rd_bank_q;
  assign used_cnt    = cnt_q;
  assign rd_data_vld = rd_vld_q;
  assign err_flags   = err_q;

  assign do_write   = wr_en      & wr_rdy;
  assign do_commit  = wr_commit  & wr_rdy;
  assign do_read    = rd_en      & rd_bank_vld;
  assign do_release = rd_release & rd_bank_vld;

  // Protocol violations detected this cycle.
  always_comb begin
    err_set                = '0;
    err_set[ERR_WR_FULL]   = (wr_en | wr_commit) & ~wr_rdy;
    err_set[ERR_RD_EMPTY]  = rd_en & ~rd_bank_vld;
    err_set[ERR_REL_EMPTY] = rd_release & ~rd_bank_vld;
  end

  // Pointers, occupancy, read-valid pipeline and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_q <= '0;
      rd_bank_q <= '0;
      cnt_q     <= '0;
      rd_vld_q  <= 1'b0;
      err_q     <= '0;
    end else begin
      if (do_commit)  wr_bank_q <= next_bank(wr_bank_q);
      if (do_release) rd_bank_q <= next_bank(rd_bank_q);
      case ({do_commit, do_release})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
      rd_vld_q <= do_read;
      // A new error in the same cycle as err_clr still sets its flag.
      err_q    <= err_clr ? t_lb_err_s'(err_set) : t_lb_err_s'(err_q | err_set);
    end
  end

  // {bank, addr} equals bank*2**ADDR_W + addr.
  qdec_sdp_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (do_write),
    .waddr ({wr_bank_q, wr_addr}),
    .wdata (wr_data),
    .re    (do_read),
    .raddr ({rd_bank_q, rd_addr}),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_qdec_ctu_syntax_buf.sv
// Bench for qdec_ctu_syntax_buf with NUM_BANKS=3, ADDR_W=4, DATA_W=8.
// The reference model keeps a flat word array and a queue of committed bank
// indices. Occupancy is the queue size, and the read bank is the queue head.
module tb_qdec_ctu_syntax_buf;

  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 4;
  localparam int NUM_BANKS = 3;
  localparam int BANK_W    = 2;
  localparam int CNT_W     = 2;
  localparam int WORDS     = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_en = 1'b0, wr_commit = 1'b0;
  logic              wr_rdy;
  logic [BANK_W-1:0] wr_bank;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic              rd_en = 1'b0, rd_release = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_data_vld, rd_bank_vld;
  logic [BANK_W-1:0] rd_bank;
  logic [CNT_W-1:0]  used_cnt;
  logic [2:0]        err_flags;
  logic              err_clr = 1'b0;

  qdec_ctu_syntax_buf #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_BANKS(NUM_BANKS)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .wr_commit(wr_commit),
    .wr_rdy(wr_rdy), .wr_bank(wr_bank),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data), .rd_data_vld(rd_data_vld),
    .rd_release(rd_release), .rd_bank_vld(rd_bank_vld), .rd_bank(rd_bank),
    .used_cnt(used_cnt), .err_flags(err_flags), .err_clr(err_clr)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [DATA_W-1:0] m_mem   [NUM_BANKS*WORDS];
  bit                m_known [NUM_BANKS*WORDS];
  int                commit_q[$];
  int                m_wr_bank = 0;
  logic [2:0]        m_err = '0;
  logic [DATA_W-1:0] m_rd_data = '0;
  bit                m_rd_vld = 1'b0;
  bit                m_rd_known = 1'b1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply the rules to the inputs present at this edge, using pre-edge state.
  task automatic model_edge();
    bit         wr_ok, rd_ok;
    int         old_wr, old_rd, a;
    logic [2:0] new_err;
    if (rst) begin
      commit_q.delete();
      m_wr_bank  = 0;
      m_err      = '0;
      m_rd_data  = '0;
      m_rd_vld   = 1'b0;
      m_rd_known = 1'b1;
      return;
    end
    wr_ok   = (commit_q.size() < NUM_BANKS);
    rd_ok   = (commit_q.size() > 0);
    old_wr  = m_wr_bank;
    old_rd  = rd_ok ? commit_q[0] : m_wr_bank;
    new_err = '0;
    m_rd_vld = 1'b0;
    if (rd_en) begin
      if (rd_ok) begin
        a          = old_rd * WORDS + int'(rd_addr);
        m_rd_vld   = 1'b1;
        m_rd_data  = m_mem[a];
        m_rd_known = m_known[a];
      end else new_err[1] = 1'b1;
    end
    if (wr_en) begin
      if (wr_ok) begin
        a          = old_wr * WORDS + int'(wr_addr);
        m_mem[a]   = wr_data;
        m_known[a] = 1'b1;
      end else new_err[0] = 1'b1;
    end
    if (rd_release) begin
      if (rd_ok) void'(commit_q.pop_front());
      else new_err[2] = 1'b1;
    end
    if (wr_commit) begin
      if (wr_ok) begin
        commit_q.push_back(old_wr);
        m_wr_bank = (old_wr + 1) % NUM_BANKS;
      end else new_err[0] = 1'b1;
    end
    m_err = err_clr ? new_err : (m_err | new_err);
  endtask

  task automatic check_outputs();
    int exp_rd_bank;
    exp_rd_bank = (commit_q.size() > 0) ? commit_q[0] : m_wr_bank;
    check_val("wr_rdy",      wr_rdy,      commit_q.size() < NUM_BANKS);
    check_val("rd_bank_vld", rd_bank_vld, commit_q.size() > 0);
    check_val("used_cnt",    used_cnt,    commit_q.size());
    check_val("wr_bank",     wr_bank,     m_wr_bank);
    check_val("rd_bank",     rd_bank,     exp_rd_bank);
    check_val("err_flags",   err_flags,   m_err);
    check_val("rd_data_vld", rd_data_vld, m_rd_vld);
    if (m_rd_known) check_val("rd_data", rd_data, m_rd_data);
  endtask

  // ---------------- driver tasks ----------------
  // One clock: drive inputs after the falling edge, update the model at the
  // rising edge, then check on the next falling edge.
  task automatic step(input bit we, input int wa, input int wd, input bit wc,
                      input bit re, input int ra, input bit rr, input bit ec);
    wr_en = we; wr_addr = ADDR_W'(wa); wr_data = DATA_W'(wd); wr_commit = wc;
    rd_en = re; rd_addr = ADDR_W'(ra); rd_release = rr; err_clr = ec;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle();                        step(0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic wr(input int a, input int d);  step(1, a, d, 0, 0, 0, 0, 0); endtask
  task automatic commit();                      step(0, 0, 0, 1, 0, 0, 0, 0); endtask
  task automatic rd(input int a);               step(0, 0, 0, 0, 1, a, 0, 0); endtask
  task automatic release_bank();                step(0, 0, 0, 0, 0, 0, 1, 0); endtask
  task automatic clr();                         step(0, 0, 0, 0, 0, 0, 0, 1); endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    rst = 1'b0;
  endtask

  task automatic fill_bank(input int base);
    for (int i = 0; i < WORDS; i++) wr(i, base + i);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    for (int i = 0; i < NUM_BANKS*WORDS; i++) begin
      m_mem[i] = '0; m_known[i] = 1'b0;
    end
    @(negedge clk);
    do_reset();
    idle();
    check_val("rst_wr_rdy", wr_rdy, 1);
    check_val("rst_rd_bank_vld", rd_bank_vld, 0);
    check_val("rst_used_cnt", used_cnt, 0);
    check_val("rst_err_flags", err_flags, 0);
    check_val("rst_rd_data", rd_data, 0);

    // Single bank: write, commit, read one word.
    fill_bank(8'hA0);
    commit();
    check_val("c1_used_cnt", used_cnt, 1);
    check_val("c1_rd_bank", rd_bank, 0);
    rd(5);
    check_val("c1_rd_data", rd_data, 8'hA5);
    check_val("c1_rd_vld", rd_data_vld, 1);
    idle();
    check_val("c1_vld_drop", rd_data_vld, 0);
    check_val("c1_rd_hold", rd_data, 8'hA5);

    // Fill every bank, then try to write into a full buffer.
    fill_bank(8'hB0); commit();
    fill_bank(8'hC0); commit();
    wr(0, 8'hFF);
    check_val("full_wr_rdy", wr_rdy, 0);
    check_val("full_err", err_flags, 3'b001);
    for (int i = 0; i < WORDS; i++) rd(i);
    check_val("full_b0_last", rd_data, 8'hAF);
    // Free bank 0, recommit it untouched, drain banks 1 and 2, reread bank 0.
    release_bank();
    commit();
    release_bank();
    release_bank();
    check_val("recommit_rd_bank", rd_bank, 0);
    for (int i = 0; i < WORDS; i++) begin
      rd(i);
      check_val("noclobber", rd_data, 8'hA0 + i);
    end

    // Pointer wrap: 3 commits, 3 releases, 1 more commit.
    do_reset();
    commit(); commit(); commit();
    check_val("wrap_wr_bank", wr_bank, 0);
    release_bank(); release_bank(); release_bank();
    commit();
    check_val("wrap_rd_bank", rd_bank, 0);
    check_val("wrap_used_cnt", used_cnt, 1);
    check_val("wrap_wr_bank2", wr_bank, 1);

    // Commit and release together while full: only the release is taken.
    commit(); commit();
    check_val("both_pre_cnt", used_cnt, 3);
    step(0, 0, 0, 1, 0, 0, 1, 0);
    check_val("both_cnt", used_cnt, 2);
    check_val("both_err0", err_flags[0], 1);
    // Commit and release together while not full: the count is unchanged.
    step(0, 0, 0, 1, 0, 0, 1, 0);
    check_val("both_legal_cnt", used_cnt, 2);

    // Read and release on an empty buffer.
    clr();
    release_bank(); release_bank();
    step(0, 0, 0, 0, 1, 3, 1, 0);
    check_val("empty_vld", rd_data_vld, 0);
    check_val("empty_err", err_flags, 3'b110);
    clr();
    check_val("clr_err", err_flags, 3'b000);
    // A new error in the same cycle as err_clr keeps its flag.
    step(0, 0, 0, 0, 1, 0, 0, 1);
    check_val("clr_vs_err", err_flags, 3'b010);

    // Reset in the middle of filling a bank.
    commit();
    wr(1, 8'h11); wr(2, 8'h22);
    do_reset();
    check_val("midrst_wr_bank", wr_bank, 0);
    check_val("midrst_rd_bank", rd_bank, 0);
    check_val("midrst_used_cnt", used_cnt, 0);

    // Randomized traffic with occasional error clears and rare resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      else step($urandom_range(0, 99) < 40, $urandom_range(0, WORDS-1), $urandom_range(0, 255),
                $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 40,
                $urandom_range(0, WORDS-1), $urandom_range(0, 99) < 8,
                $urandom_range(0, 99) < 5);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
